// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter and sequencer for a shared 32x32 signed shift-add multiplier.
// Optional build macro: MUL_EARLY_TERM_EN (stop iterating once the multiplier runs out of set bits).
module mul_share_ctrl #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [63:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  localparam int NSLOT = 2 ** IDW;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_sign;
  logic [63:0]    r_m;
  logic [63:0]    r_p;
  logic [31:0]    r_r;
  logic [4:0]     r_cnt;
  logic           r_resp_valid;
  logic [63:0]    r_resp_data;
  logic [IDW-1:0] r_resp_id;

  // Requester inputs padded out to 2**IDW slots so an IDW-bit index is always in range.
  logic [NSLOT-1:0] w_valid_ext;
  logic [31:0]      w_a_ext [NSLOT];
  logic [31:0]      w_b_ext [NSLOT];

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NREQ) begin : g_live
        assign w_valid_ext[gi] = req_valid[gi];
        assign w_a_ext[gi]     = req_a[32*gi +: 32];
        assign w_b_ext[gi]     = req_b[32*gi +: 32];
      end else begin : g_pad
        assign w_valid_ext[gi] = 1'b0;
        assign w_a_ext[gi]     = 32'd0;
        assign w_b_ext[gi]     = 32'd0;
      end
    end
  endgenerate

  logic           w_found;
  logic [IDW-1:0] w_gnt_idx;
  logic [IDW:0]   w_sum;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ)) begin
        w_sum = w_sum - (IDW+1)'(NREQ);
      end
      if (!w_found && w_valid_ext[w_sum[IDW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[IDW-1:0];
      end
    end
  end

  logic w_accept;
  assign w_accept = (r_state == IDLE) && w_found && !rst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_accept && (w_gnt_idx == IDW'(gi));
    end
  endgenerate

  logic [31:0]    w_sel_a;
  logic [31:0]    w_sel_b;
  logic [31:0]    w_abs_a;
  logic [31:0]    w_abs_b;
  logic [IDW-1:0] w_rr_next;
  assign w_sel_a   = w_a_ext[w_gnt_idx];
  assign w_sel_b   = w_b_ext[w_gnt_idx];
  // Magnitude of -2^31 wraps to 0x8000_0000, which is correct when read as unsigned.
  assign w_abs_a   = w_sel_a[31] ? (~w_sel_a + 32'd1) : w_sel_a;
  assign w_abs_b   = w_sel_b[31] ? (~w_sel_b + 32'd1) : w_sel_b;
  assign w_rr_next = (w_gnt_idx == IDW'(NREQ-1)) ? '0 : (w_gnt_idx + IDW'(1));

  logic [31:0] w_r_shift;
  logic [63:0] w_p_add;
  logic        w_run_last;
  assign w_r_shift = r_r >> 1;
  assign w_p_add   = r_r[0] ? (r_p + r_m) : r_p;
`ifdef MUL_EARLY_TERM_EN
  assign w_run_last = (w_r_shift == 32'd0) || (r_cnt == 5'd31);
`else
  assign w_run_last = (r_cnt == 5'd31);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_sign       <= 1'b0;
      r_m          <= '0;
      r_p          <= '0;
      r_r          <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign    <= w_sel_a[31] ^ w_sel_b[31];
            r_m       <= {32'd0, w_abs_a};
            r_r       <= w_abs_b;
            r_p       <= '0;
            r_cnt     <= '0;
            r_resp_id <= w_gnt_idx;
            r_rr_ptr  <= w_rr_next;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_p   <= w_p_add;
          r_m   <= r_m << 1;
          r_r   <= w_r_shift;
          r_cnt <= r_cnt + 5'd1;
          if (w_run_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          // Negating a zero magnitude yields zero, so -0 results come out clean.
          r_resp_data  <= r_sign ? (~r_p + 64'd1) : r_p;
          r_resp_valid <= 1'b1;
          r_state      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: driver predicts grants and products, monitor checks responses.
// Build with +define+MUL_EARLY_TERM_EN to expect early-termination latencies.
module tb_mul_share_ctrl;
  localparam int NREQ = 3;
  localparam int IDW  = 3;
`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready;
  logic [63:0]         resp_data;
  logic [IDW-1:0]      resp_id;
  logic                busy;

  mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    int             acc;
    int             lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  bit          pend [NREQ];
  logic [31:0] ma   [NREQ];
  logic [31:0] mb   [NREQ];
  int          rr_model   = 0;
  bit          idle_model = 1'b1;
  int          rmode      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb_ = longint'($signed(b));
    return 64'(sa * sb_);
  endfunction

  function automatic int ref_latency(input logic [31:0] b);
    longint mag = longint'($signed(b));
    int     nb  = 0;
    if (mag < 0) mag = -mag;
    for (int k = 0; k < 33; k++) if (mag[k]) nb = k + 1;
    if (EARLY) return 2 + ((nb == 0) ? 1 : nb);
    return 34;
  endfunction

  function automatic logic [31:0] rand_op();
    int sel = int'($urandom_range(0, 9));
    case (sel)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = pend[i];
      req_a[32*i +: 32]    = ma[i];
      req_b[32*i +: 32]    = mb[i];
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    pend[i] = 1'b1;
    ma[i]   = a;
    mb[i]   = b;
    drive_inputs();
  endtask

  // One clock of driver activity: predict grant, check handshake outputs, then update inputs.
  task automatic step();
    int              g;
    int              idx;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    @(negedge clk);
    g = -1;
    if (idle_model) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr_model + k) % NREQ;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(!idle_model));
    if (g >= 0) begin
      e.id   = IDW'(g);
      e.data = ref_product(ma[g], mb[g]);
      e.acc  = cyc;
      e.lat  = ref_latency(mb[g]);
      sb.push_back(e);
      $display("accept cyc=%0d id=%0d a=%h b=%h", cyc, g, ma[g], mb[g]);
      pend[g]    = 1'b0;
      rr_model   = (g + 1) % NREQ;
      idle_model = 1'b0;
    end else if (!idle_model && resp_valid && resp_ready) begin
      idle_model = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rmode == 1) resp_ready = ($urandom_range(0, 2) != 0);
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    idle_model = 1'b1;
    rr_model   = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();
  endtask

  function automatic bit any_pend();
    for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (!(idle_model && sb.size() == 0 && !any_pend()) && n < budget) begin
      step();
      n++;
    end
    nvec++;
    if (n >= budget) begin
      nerr++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  // Monitor: pops an expectation on each new response and checks holding during back-pressure.
  initial begin
    bit             held_v;
    logic [63:0]    hd;
    logic [IDW-1:0] hid;
    exp_t           e;
    held_v = 1'b0;
    hd     = '0;
    hid    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (resp_valid && !held_v) begin
          if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL spurious_resp: got resp_valid=1 data=%h, required no response", resp_data);
          end else begin
            e = sb.pop_front();
            check("resp_data", resp_data, e.data);
            check("resp_id", 64'(resp_id), 64'(e.id));
            check("latency", 64'(cyc - e.acc), 64'(e.lat));
            $display("resp cyc=%0d id=%0d data=%h lat=%0d", cyc, resp_id, resp_data, cyc - e.acc);
          end
          hd  = resp_data;
          hid = resp_id;
        end else if (resp_valid && held_v) begin
          check("hold_data", resp_data, hd);
          check("hold_id", 64'(resp_id), 64'(hid));
        end
        held_v = resp_valid && !resp_ready;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    resp_ready = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      ma[i]   = '0;
      mb[i]   = '0;
    end
    do_reset();

    // Directed products, including the extreme-magnitude corners.
    issue(0, 32'd3, 32'hFFFF_FFFB);
    drain(200);
    issue(0, 32'h8000_0000, 32'h8000_0000);
    drain(200);
    issue(1, 32'h7FFF_FFFF, 32'h8000_0000);
    drain(200);
    issue(2, 32'h8000_0000, 32'd0);
    drain(200);
    issue(0, 32'd7, 32'd1);
    drain(200);
    issue(1, 32'd5, 32'd0);
    drain(200);

    // Two requests held from reset, then a lone request from requester 1.
    pend[0] = 1'b1; ma[0] = 32'd2;           mb[0] = 32'd3;
    pend[1] = 1'b1; ma[1] = 32'hFFFF_FFF9;   mb[1] = 32'd4;
    do_reset();
    drain(300);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain(200);

    // Back-pressure: hold resp_ready low for 5 cycles after the response appears.
    resp_ready = 1'b0;
    rmode      = 2;
    issue(2, 32'h1234_5678, 32'h9ABC_DEF0);
    n = 0;
    while (!resp_valid && n < 100) begin
      step();
      n++;
    end
    repeat (5) step();
    resp_ready = 1'b1;
    rmode      = 0;
    drain(200);

    // Abort with reset during RUN cycle 10; nothing may come back for that request.
    issue(0, 32'd11, 32'd13);
    n = 0;
    while (idle_model && n < 20) begin
      step();
      n++;
    end
    repeat (9) step();
    do_reset();
    repeat (40) step();
    issue(1, 32'hFFFF_FF00, 32'd77);
    drain(200);

    // Randomized traffic with random back-pressure and occasional withdrawals.
    rmode = 1;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1;
          ma[i]   = rand_op();
          mb[i]   = rand_op();
        end else if (pend[i] && $urandom_range(0, 63) == 0) begin
          pend[i] = 1'b0;
        end
      end
      drive_inputs();
      step();
    end
    rmode      = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive_inputs();
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequencing and arbitration controller for the 32x32 signed multiplier datapath.
- NREQ requesters share one iterative shift-add multiply engine built around the team's 64-bit adder.
- Round-robin grant, per-request valid/ready handshake, 32-cycle radix-2 iteration, sign fix-up, then a held response.
- Sits between the integer execute units and the shared 64-bit adder resource.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 3, width of resp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_a  input  32*NREQ  signed multiplicand; requester i uses bits [32i+31:32i].
- req_b  input  32*NREQ  signed multiplier, same packing as req_a.
- req_ready  output  NREQ  one-hot accept strobe.
- resp_valid  output  1  product available.
- resp_ready  input  1  consumer accepts product.
- resp_data  output  64  signed product a*b.
- resp_id  output  IDW  index of the requester that owns resp_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, rr_ptr=0, state=IDLE, all internal registers 0.
- rst high in any state, including mid-RUN, aborts the operation; the in-flight result is discarded and no response is issued.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE, grant selection:
  - Grant the first index i with req_valid[i]=1, searching upward from rr_ptr and wrapping modulo NREQ.
  - req_ready[i]=1 combinationally in the same cycle. This is the handshake cycle (cycle 0).
  - Capture sign s = a[31]^b[31], M = zero-extended |a| (64b), R = |b| (32b unsigned), P = 0, cnt = 0, resp_id = i.
  - Update rr_ptr = (i+1) mod NREQ, then go to RUN.
  - If no req_valid bit is set, stay in IDLE.
- |x| is computed as ~x+1 when x[31]=1. |-2^31| = 0x8000_0000 as unsigned; this is legal.
- RUN, one iteration per cycle:
  - If R[0]=1, P = P+M (64b, carry out discarded).
  - Then M = M<<1, R = R>>1, cnt = cnt+1.
  - Go to FIX after the iteration with cnt==31, i.e. 32 RUN cycles, cycles 1..32.
- FIX (cycle 33): resp_data = s ? (~P+1) : P. Go to DONE.
- DONE (cycle 34 onward):
  - resp_valid=1; resp_data and resp_id stay stable until resp_ready=1.
  - On resp_valid & resp_ready, go to IDLE and drop resp_valid the next cycle.
  - resp_data keeps its last value while idle.
- Accept-to-resp_valid latency is 34 cycles.
- Minimum spacing between handshakes is 35 cycles: no accept in the same cycle as a response handshake.
- req_ready is 0 in every state except IDLE.
- Requesters must hold req_valid, req_a and req_b stable until accepted. Deasserting before acceptance is allowed; the bit is simply not granted.
- Product width: the full 64-bit product never overflows. The extreme case is (-2^31)*(-2^31) = 0x4000_0000_0000_0000.
- Any operand equal to 0 yields resp_data=0, including negative-zero cases: s=1 and P=0 give 0.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined:
  - In RUN, exit to FIX after any iteration in which the shifted R becomes 0.
  - Latency = 2 + (index of the highest set bit of |b|, plus 1). For b=0, exactly one RUN cycle, so latency 3.
  - Results are identical to the non-early-termination case.
- Undefined: always 32 RUN cycles, fixed latency 34.

Test Plan:
- After reset, requester 0 sends a=3, b=-5; resp_ready=1 -> resp_valid at cycle 34, resp_data=0xFFFF_FFFF_FFFF_FFF1, resp_id=0.
- a=0x8000_0000, b=0x8000_0000 -> resp_data=0x4000_0000_0000_0000. Also a=0x7FFF_FFFF, b=0x8000_0000 -> 0xC000_0000_8000_0000.
- req_valid=2'b11 held from reset with a0=2,b0=3 and a1=-7,b1=4 -> first response id=0 data=6, second id=1 data=0xFFFF_FFFF_FFFF_FFE4. Then only req1 valid -> granted, since rr_ptr wraps to 0 and searches upward.
- resp_ready held 0 for 5 cycles after resp_valid -> resp_data and resp_id stable, req_ready stays 0 throughout, IDLE only after resp_ready=1.
- Assert rst for 1 cycle at cycle 10 of RUN -> all outputs at reset values next cycle, no resp_valid ever for that request. A new request afterwards completes correctly.
- MUL_EARLY_TERM_EN defined: a=7, b=1 -> resp_valid at cycle 3, data=7. a=5, b=0 -> cycle 3, data=0. Undefined: both at cycle 34.
